// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS
// core. Sequences the PC, captures the fetched word into IF/ID, holds on a
// load-use stall, flushes the wrong-path fetch on a redirect (no delay slot)
// and freezes the core after a syscall until reset.
//
// Ports:
//   clk             in   1   system clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   imem_addr       out  32  instruction memory byte address (= pc)
//   imem_rdata      in   32  instruction word at imem_addr (combinational)
//   stall           in   1   load-use hazard: hold PC and IF/ID
//   id_jump         in   1   j/jal decoded for the IF/ID instruction
//   id_jr           in   1   jr decoded for the IF/ID instruction
//   id_branch_taken in   1   branch resolved taken in ID
//   id_finish       in   1   syscall decoded
//   jr_target       in   32  forwarded rs value for jr
//   pc              out  32  current fetch PC
//   if_id_instr     out  32  IF/ID instruction word
//   if_id_pc_plus4  out  32  PC+4 of the IF/ID instruction
//   if_id_valid     out  1   IF/ID holds a real instruction
//   halted          out  1   core halted after syscall
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        id_jump,
    input  logic        id_jr,
    input  logic        id_branch_taken,
    input  logic        id_finish,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state, state_next;

    logic [31:0] pc_next;
    logic [31:0] instr_next;
    logic [31:0] pc4_next;
    logic        valid_next;

    // Control from ID only means something when IF/ID holds a real instruction.
    logic        q_jump, q_jr, q_branch, q_finish, redirect;
    logic [31:0] seq_pc;
    logic [31:0] branch_off;
    logic [31:0] target;

    assign q_jump   = if_id_valid & id_jump;
    assign q_jr     = if_id_valid & id_jr;
    assign q_branch = if_id_valid & id_branch_taken;
    assign q_finish = if_id_valid & id_finish;
    assign redirect = q_jump | q_jr | q_branch;

    assign seq_pc     = pc + 32'd4;
    assign branch_off = {{14{if_id_instr[15]}}, if_id_instr[15:0], 2'b00};

    // Target priority: jr > jump > branch.
    always_comb begin
        if (q_jr)
            target = jr_target;
        else if (q_jump)
            target = {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00};
        else
            target = if_id_pc_plus4 + branch_off;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_next;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_next = state;
        if (state == RUN && q_finish && !stall)
            state_next = HALT;
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        pc_next    = pc;
        instr_next = if_id_instr;
        pc4_next   = if_id_pc_plus4;
        valid_next = if_id_valid;
        if (state == RUN) begin
            if (q_finish && !stall) begin
                // Halt: PC freezes, the syscall leaves IF/ID as a bubble.
                instr_next = NOP_WORD;
                valid_next = 1'b0;
            end else if (stall) begin
                // Hold everything; ID re-presents any redirect next cycle.
            end else if (redirect) begin
                pc_next    = target;
                instr_next = NOP_WORD;
                valid_next = 1'b0;
            end else begin
                pc_next    = seq_pc;
                instr_next = imem_rdata;
                pc4_next   = seq_pc;
                valid_next = 1'b1;
            end
        end
    end

    // NOTE: these are a handful of pipeline flops, not a memory, so all of
    // them take the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= PC_RESET;
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else begin
            pc             <= pc_next;
            if_id_instr    <= instr_next;
            if_id_pc_plus4 <= pc4_next;
            if_id_valid    <= valid_next;
        end
    end

    assign imem_addr = pc;
    assign halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A small instruction ROM model answers
// imem_addr combinationally; ID-stage control is driven directly. Expected
// values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        id_jump;
    logic        id_jr;
    logic        id_branch_taken;
    logic        id_finish;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    // 128-word ROM covering 0x3000..0x31FC; anything else reads as 0.
    logic [31:0] mem [0:127];

    function automatic logic [31:0] imem_read(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - 32'h0000_3000;
        if (addr >= 32'h0000_3000 && addr < 32'h0000_3200)
            return mem[off[8:2]];
        return 32'h0;
    endfunction

    assign imem_rdata = imem_read(imem_addr);

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .id_jump         (id_jump),
        .id_jr           (id_jr),
        .id_branch_taken (id_branch_taken),
        .id_finish       (id_finish),
        .jr_target       (jr_target),
        .pc              (pc),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_valid     (if_id_valid),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Compare the whole visible state against expected constants.
    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_valid, input logic e_halted);
        check({tag, ".pc"},        pc,                     e_pc);
        check({tag, ".imem_addr"}, imem_addr,              e_pc);
        check({tag, ".instr"},     if_id_instr,            e_instr);
        check({tag, ".pc4"},       if_id_pc_plus4,         e_pc4);
        check({tag, ".valid"},     {31'd0, if_id_valid},   {31'd0, e_valid});
        check({tag, ".halted"},    {31'd0, halted},        {31'd0, e_halted});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall           = 1'b0;
        id_jump         = 1'b0;
        id_jr           = 1'b0;
        id_branch_taken = 1'b0;
        id_finish       = 1'b0;
        jr_target       = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0]  = 32'h2008_0005;   // 0x3000 addi
        mem[1]  = 32'h3C01_1001;   // 0x3004 lui
        mem[2]  = 32'h1109_FFFE;   // 0x3008 beq -2
        mem[3]  = 32'h0800_0C10;   // 0x300C j 0x3040
        mem[4]  = 32'h0000_0020;   // 0x3010
        mem[16] = 32'h0000_0020;   // 0x3040 add
        mem[63] = 32'h0000_000C;   // 0x30FC syscall
        mem[64] = 32'h1109_FFFE;   // 0x3100 beq -2

        rst_n = 1'b0;
        clear_ctrl();
        #12;
        check_all("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Sequential fetch.
        tick(); check_all("seq1", 32'h3004, 32'h2008_0005, 32'h3004, 1'b1, 1'b0);
        tick(); check_all("seq2", 32'h3008, 32'h3C01_1001, 32'h3008, 1'b1, 1'b0);
        tick(); check_all("seq3", 32'h300C, 32'h1109_FFFE, 32'h300C, 1'b1, 1'b0);

        // Taken branch: 0x300C + (-2 << 2) = 0x3004, IF/ID flushed.
        id_branch_taken = 1'b1;
        tick(); check_all("br_taken", 32'h3004, 32'h0, 32'h300C, 1'b0, 1'b0);
        clear_ctrl();
        tick(); check_all("br_refetch1", 32'h3008, 32'h3C01_1001, 32'h3008, 1'b1, 1'b0);
        tick(); check_all("br_refetch2", 32'h300C, 32'h1109_FFFE, 32'h300C, 1'b1, 1'b0);

        // Same branch not taken: fall through.
        tick(); check_all("br_not_taken", 32'h3010, 32'h0800_0C10, 32'h3010, 1'b1, 1'b0);

        // Jump: {0x0, 0x0000C10, 00} = 0x3040.
        id_jump = 1'b1;
        tick(); check_all("jump", 32'h3040, 32'h0, 32'h3010, 1'b0, 1'b0);

        // Control while IF/ID is a bubble must be ignored.
        id_branch_taken = 1'b1;
        id_jr           = 1'b1;
        jr_target       = 32'h0000_3100;
        tick(); check_all("bubble_ignore", 32'h3044, 32'h0000_0020, 32'h3044, 1'b1, 1'b0);
        clear_ctrl();

        // jr beats jump and branch.
        id_jr           = 1'b1;
        id_jump         = 1'b1;
        id_branch_taken = 1'b1;
        jr_target       = 32'h0000_3100;
        tick(); check_all("jr_prio", 32'h3100, 32'h0, 32'h3044, 1'b0, 1'b0);
        clear_ctrl();
        tick(); check_all("jr_fetch", 32'h3104, 32'h1109_FFFE, 32'h3104, 1'b1, 1'b0);

        // Stall two cycles with a taken branch: nothing moves.
        stall           = 1'b1;
        id_branch_taken = 1'b1;
        tick(); check_all("stall1", 32'h3104, 32'h1109_FFFE, 32'h3104, 1'b1, 1'b0);
        tick(); check_all("stall2", 32'h3104, 32'h1109_FFFE, 32'h3104, 1'b1, 1'b0);
        stall = 1'b0;
        // 0x3104 - 8 = 0x30FC.
        tick(); check_all("stall_release", 32'h30FC, 32'h0, 32'h3104, 1'b0, 1'b0);
        clear_ctrl();
        tick(); check_all("syscall_fetch", 32'h3100, 32'h0000_000C, 32'h3100, 1'b1, 1'b0);

        // Finish blocked by stall, then taken.
        id_finish = 1'b1;
        stall     = 1'b1;
        tick(); check_all("finish_stalled", 32'h3100, 32'h0000_000C, 32'h3100, 1'b1, 1'b0);
        stall = 1'b0;
        tick(); check_all("halt", 32'h3100, 32'h0, 32'h3100, 1'b0, 1'b1);
        clear_ctrl();

        // Halted: control ignored.
        id_jump = 1'b1;
        id_jr   = 1'b1;
        jr_target = 32'h0000_3000;
        tick(); check_all("halt_hold1", 32'h3100, 32'h0, 32'h3100, 1'b0, 1'b1);
        stall = 1'b1;
        tick(); check_all("halt_hold2", 32'h3100, 32'h0, 32'h3100, 1'b0, 1'b1);
        clear_ctrl();

        // Reset out of HALT, mid-cycle.
        #2 rst_n = 1'b0;
        #1 check_all("reset_halt", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;

        // Run to pc=0x3010, then reset mid-run.
        tick(); tick(); tick(); tick();
        check("run_pc", pc, 32'h3010);
        #2 rst_n = 1'b0;
        #1 check_all("reset_midrun", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        tick(); check_all("post_reset", 32'h3004, 32'h2008_0005, 32'h3004, 1'b1, 1'b0);

        // Misaligned jr passes through; then PC wraps at 2^32.
        id_jr     = 1'b1;
        jr_target = 32'h0000_3102;
        tick(); check("jr_misaligned", pc, 32'h0000_3102);
        clear_ctrl();
        tick();
        id_jr     = 1'b1;
        jr_target = 32'hFFFF_FFFC;
        tick(); check("jr_top", pc, 32'hFFFF_FFFC);
        clear_ctrl();
        tick(); check_all("wrap", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
- Drives the instruction word whose Op/Funct fields feed the control decoder.
- Consumes the decoder's resolved control results (jump, jr, taken branch, finish) to redirect or halt the PC.
- Owns PC sequencing, the IF/ID register, stall hold, redirect flush, and halt on syscall.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  32  instruction memory byte address; always equals pc.
- imem_rdata  input  32  instruction word at imem_addr; combinational read, valid in the same cycle.
- stall  input  1  load-use hazard from the hazard unit; hold PC and IF/ID.
- id_jump  input  1  decoded j/jal for the instruction in IF/ID.
- id_jr  input  1  decoded jr for the instruction in IF/ID.
- id_branch_taken  input  1  Branch AND operands equal, resolved in ID.
- id_finish  input  1  decoded syscall.
- jr_target  input  32  forwarded rs value for jr.
- pc  output  32  current fetch PC.
- if_id_instr  output  32  IF/ID instruction; bits [31:26] drive Op and [5:0] drive Funct.
- if_id_pc_plus4  output  32  PC+4 of the IF/ID instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  core halted after syscall.

Behaviour:
- Reset (async, rst_n=0):
  - pc=PC_RESET, if_id_instr=NOP_WORD, if_id_pc_plus4=0, if_id_valid=0, halted=0, state=RUN.
  - Takes effect immediately, including mid-redirect or in HALT.
- State machine:
  - RUN → HALT when if_id_valid & id_finish & !stall at a clock edge.
  - HALT is left only by reset.
- Control inputs (id_*) are qualified internally with if_id_valid. They are ignored when if_id_valid=0.
- Redirect target priority when more than one is asserted: jr > jump > branch.
  - jr: jr_target.
  - jump: {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}.
  - branch: if_id_pc_plus4 + (sign_extend(if_id_instr[15:0]) << 2), 32-bit, wraps modulo 2^32.
- Per-edge update in RUN, first matching rule wins:
  1. Finish (qualified, !stall): pc holds; IF/ID ← bubble (NOP_WORD, valid=0); state ← HALT; halted ← 1.
  2. stall=1: pc, if_id_instr, if_id_pc_plus4, if_id_valid all hold. Redirect inputs are ignored this cycle; ID re-presents them next cycle.
  3. Redirect (qualified jr/jump/branch_taken): pc ← target. IF/ID ← bubble, flushing the wrong-path fetch (no delay slot). One-cycle redirect penalty.
  4. Otherwise: pc ← pc+4 (wraps at 2^32); if_id_instr ← imem_rdata; if_id_pc_plus4 ← pc+4; if_id_valid ← 1.
- In HALT: all registers hold, halted=1, and stall and id_* inputs are ignored.
- Latency: an instruction fetched at edge N is presented on if_id_* after edge N. The redirect target is fetched in the cycle after the redirect edge.
- The jal link value is if_id_pc_plus4, carried downstream by later stages. This block does not write registers.
- pc bits [1:0] stay 00 except under jr to a misaligned jr_target, which is passed through unchecked.
- All outputs are registered except imem_addr, which is a wire from pc.

Test Plan:
- Reset: assert rst_n=0 mid-run at pc=0x3010 → immediately pc=0x3000, if_id_valid=0, if_id_instr=0, halted=0. Release → first edge gives if_id_instr=imem[0x3000], if_id_pc_plus4=0x3004, pc=0x3004.
- Sequential fetch: imem 0x3000=0x20080005, 0x3004=0x3C011001 → after 2 edges if_id_instr=0x3C011001, if_id_pc_plus4=0x3008, pc=0x3008, if_id_valid=1.
- Branch: beq 0x1109FFFE in IF/ID with pc_plus4=0x300C, id_branch_taken=1 → next edge pc=0x3004, if_id_valid=0. Same instruction with id_branch_taken=0 → pc=0x3010 and normal fetch.
- Jump/jr: j 0x08000C10 with pc_plus4=0x3004 → pc=0x3040 and bubble. jr with jr_target=0x3100 while id_jump=1 also asserted → pc=0x3100 (jr wins).
- Stall: stall=1 for 2 cycles with id_branch_taken=1 → pc and if_id_* unchanged both cycles, no redirect. Stall drops → redirect applied on the following edge.
- Finish: syscall 0x0000000C in IF/ID, id_finish=1, stall=0 → next edge halted=1, if_id_valid=0, pc frozen. Further edges with id_jump=1 → no change until rst_n=0.
